// File: rtl/scc_sequencer.sv
// scc_sequencer: multi-cycle FETCH/DECODE/EXECUTE/MEM/WB control sequencer with PC, retire counter and fault detection
module scc_sequencer #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        run,
    input  logic        in_mem_ready,
    output logic        in_mem_en,
    output logic [31:0] in_mem_addr,
    output logic        ir_load,
    input  logic        is_halt,
    input  logic        is_mem_op,
    input  logic        is_load,
    input  logic        wb_needed,
    input  logic        is_branch,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        data_ready,
    output logic        data_en,
    output logic        data_we,
    output logic        rf_we,
    output logic        halted,
    output logic        fault,
    output logic [31:0] instr_count,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        DECODE  = 3'd2,
        EXECUTE = 3'd3,
        MEM     = 3'd4,
        WB      = 3'd5,
        HALT    = 3'd6
    } state_t;

    state_t      cur, nxt;
    logic [31:0] pc, wait_cnt, br_target;
    logic        br_take, retire, fault_set;
    logic        waiting, ready_now, timed_out, misaligned, take_now;
    logic [31:0] target_now;

    // FETCH and MEM are the only states that wait on a ready handshake
    assign waiting    = (cur == FETCH) || (cur == MEM);
    assign ready_now  = (cur == FETCH) ? in_mem_ready : data_ready;
    assign timed_out  = waiting && !ready_now && (MEM_TIMEOUT != 0) && (wait_cnt == MEM_TIMEOUT);
    assign misaligned = is_branch && branch_taken && (branch_target[1:0] != 2'b00);

    // A retire straight out of EXECUTE uses the live branch inputs; later retires use the latched decision
    assign take_now   = (cur == EXECUTE) ? (is_branch && branch_taken) : br_take;
    assign target_now = (cur == EXECUTE) ? branch_target : br_target;

    assign in_mem_en   = (cur == FETCH);
    assign in_mem_addr = pc;
    assign ir_load     = (cur == FETCH) && in_mem_ready;
    assign data_en     = (cur == MEM);
    assign data_we     = (cur == MEM) && !is_load;
    assign rf_we       = (cur == WB);
    assign halted      = (cur == HALT);
    assign state       = cur;

    // Next-state selection, retire detection and fault detection
    always_comb begin
        nxt       = cur;
        retire    = 1'b0;
        fault_set = 1'b0;
        case (cur)
            IDLE:    nxt = run ? FETCH : IDLE;
            FETCH: begin
                if (in_mem_ready) begin
                    nxt = DECODE;
                end else if (timed_out) begin
                    nxt       = HALT;
                    fault_set = 1'b1;
                end
            end
            DECODE:  nxt = is_halt ? HALT : EXECUTE;
            EXECUTE: begin
                if (misaligned) begin
                    nxt       = HALT;
                    fault_set = 1'b1;
                end else if (is_mem_op) begin
                    nxt = MEM;
                end else if (wb_needed) begin
                    nxt = WB;
                end else begin
                    retire = 1'b1;
                end
            end
            MEM: begin
                if (data_ready) begin
                    if (is_load) nxt = WB;
                    else retire = 1'b1;
                end else if (timed_out) begin
                    nxt       = HALT;
                    fault_set = 1'b1;
                end
            end
            WB:      retire = 1'b1;
            HALT:    nxt = HALT;
            default: nxt = IDLE;
        endcase
        if (retire) nxt = run ? FETCH : IDLE;
    end

    // State, PC, retire counter, wait counter, branch latch and sticky fault
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur         <= IDLE;
            pc          <= RESET_PC;
            instr_count <= 32'd0;
            fault       <= 1'b0;
            wait_cnt    <= 32'd0;
            br_take     <= 1'b0;
            br_target   <= 32'd0;
        end else begin
            cur      <= nxt;
            wait_cnt <= (waiting && !ready_now && !timed_out) ? wait_cnt + 32'd1 : 32'd0;
            if (cur == EXECUTE) begin
                br_take   <= is_branch && branch_taken;
                br_target <= branch_target;
            end
            if (retire) begin
                pc          <= take_now ? target_now : pc + 32'd4;
                instr_count <= instr_count + 32'd1;
            end
            if (fault_set) fault <= 1'b1;
        end
    end

endmodule
